disp_mux4: RTL and testbench
============================

Name:
disp_mux4

Overview:
- Time-multiplexing driver for a 4-digit common-anode seven-segment display.
- Takes four pre-encoded 8-bit segment patterns (7 segments plus decimal point) and cycles through the digits at a refresh rate set by a free-running counter.
- Enables one digit at a time and presents that digit's pattern.
- Sits between the display-encoding logic (hex/BCD-to-segment) and the board's anode and segment pins.

Parameters:
- N, default 18: width of the free-running refresh counter. Bits [N-1:N-2] select the digit; each digit is lit for 2^(N-2) clocks. 18 at 50 MHz gives 1.31 ms per digit and about 190 Hz full refresh. Minimum legal value is 2; benches use a small N such as 4.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-low reset. Asserted when 0.
- in3, input, 8: segment pattern for digit 3 (leftmost). Bit 7 = dp, bits 6..0 = g..a. Active-low, 0 = lit.
- in2, input, 8: segment pattern for digit 2.
- in1, input, 8: segment pattern for digit 1.
- in0, input, 8: segment pattern for digit 0 (rightmost).
- an, output, 4: digit enables, active-low, one-hot-zero. an[k]=0 enables digit k.
- sseg, output, 8: segment pattern for the currently enabled digit. Passed through unmodified.

Behaviour:
- Refresh counter q_reg, N bits, clocked on the rising edge of clk.
  - reset=0: q_reg is cleared to 0 immediately, independent of clk.
  - Otherwise q_reg <= q_reg + 1 every cycle.
  - Wraps from 2^N-1 to 0 with no stall and no flag.
  - No enable input; the counter always runs while out of reset.
- Select sel = q_reg[N-1:N-2]. an and sseg are pure combinational decodes of sel and the in* inputs:
  - sel=00: an=1110, sseg=in0
  - sel=01: an=1101, sseg=in1
  - sel=10: an=1011, sseg=in2
  - sel=11: an=0111, sseg=in3
- Exactly one an bit is 0 at all times, including during reset. There is no all-off state.
- Reset values: q_reg=0, an=1110, sseg=in0.
- Input changes on in* appear on sseg in the same cycle, combinationally, when that digit is selected. Inputs are not latched.
- Digit order is 0,1,2,3,0,… Each digit is held for exactly 2^(N-2) consecutive clocks.
- Each digit transition occurs on the clock edge where q_reg[N-3:0] wraps to 0. For N=2, the digit advances every clock.
- Reset mid-scan: an returns to 1110 and sseg to in0 asynchronously. After release, counting restarts from 0 on the next rising edge.
- Reset is released asynchronously. On the first rising edge after release, q_reg goes 0→1.
- No X propagation: every output bit is defined for all input values once reset has been applied.
- Implementation is two processes, a counter process and a decode process. The default decode branch drives an=1110 and sseg=in0 so the decode is fully specified.

Test Plan:
- Reset: N=4, hold reset=0 with in3=80h, in2=40h, in1=20h, in0=10h. Require an=1110, sseg=10h and q_reg=0, and that they hold across multiple clock edges.
- Scan order: N=4, release reset with in0=F0h, in1=CCh, in2=AAh, in3=81h. Require the following, then a repeat from cycle 16:
  - cycles 0–3: an=1110, sseg=F0h
  - cycles 4–7: an=1101, sseg=CCh
  - cycles 8–11: an=1011, sseg=AAh
  - cycles 12–15: an=0111, sseg=81h
- Live input: while digit 1 is selected, change in1 from CCh to 3Ch. Require sseg=3Ch in the same cycle with an unchanged. Changing in0 during this window must not affect sseg.
- Async reset mid-scan: N=4, assert reset=0 between clock edges while an=1011. Require an=1110 and sseg=in0 before the next rising edge. After release, the digit-0 dwell must last a full 4 cycles.
- One-hot check: N=2, run 64 cycles with random in*. Every cycle, require an to be one of {1110, 1101, 1011, 0111} and sseg to equal the in* input selected by an.
- Default period: N=18. Require the first an change from 1110 to 1101 exactly 65536 cycles after reset release.

Source files
------------

// File: rtl/disp_mux4.sv
// Four-digit common-anode seven-segment scan driver.
// A free-running counter picks the digit; its top two bits choose the anode and the pattern.
module disp_mux4 #(
  parameter int N = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in3,
  input  logic [7:0] in2,
  input  logic [7:0] in1,
  input  logic [7:0] in0,
  output logic [3:0] an,
  output logic [7:0] sseg
);

  logic [N-1:0] q_reg;
  logic [N-1:0] q_next;
  logic [1:0]   sel;

  assign q_next = q_reg + {{(N-1){1'b0}}, 1'b1};
  assign sel    = q_reg[N-1:N-2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q_reg <= '0;
    else        q_reg <= q_next;
  end

  // Digit 0 doubles as the default so exactly one anode is always driven low.
  always_comb begin
    an   = 4'b1110;
    sseg = in0;
    case (sel)
      2'b00: begin an = 4'b1110; sseg = in0; end
      2'b01: begin an = 4'b1101; sseg = in1; end
      2'b10: begin an = 4'b1011; sseg = in2; end
      2'b11: begin an = 4'b0111; sseg = in3; end
      default: begin an = 4'b1110; sseg = in0; end
    endcase
  end

endmodule

// File: tb/tb_disp_mux4.sv
// Bench for disp_mux4: reset, scan order, live inputs, async reset, one-hot and default period.
module tb_disp_mux4;

  logic       clk;
  logic       rst4, rst2, rst18;
  logic [7:0] a_in [4];
  logic [7:0] b_in [4];
  logic [7:0] c_in [4];
  logic [3:0] an4, an2, an18;
  logic [7:0] sseg4, sseg2, sseg18;

  int checks = 0;
  int failures = 0;

  disp_mux4 #(.N(4)) dut4 (
    .clk(clk), .reset(rst4),
    .in3(a_in[3]), .in2(a_in[2]), .in1(a_in[1]), .in0(a_in[0]),
    .an(an4), .sseg(sseg4)
  );

  disp_mux4 #(.N(2)) dut2 (
    .clk(clk), .reset(rst2),
    .in3(b_in[3]), .in2(b_in[2]), .in1(b_in[1]), .in0(b_in[0]),
    .an(an2), .sseg(sseg2)
  );

  disp_mux4 dut18 (
    .clk(clk), .reset(rst18),
    .in3(c_in[3]), .in2(c_in[2]), .in1(c_in[1]), .in0(c_in[0]),
    .an(an18), .sseg(sseg18)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: after k rising edges out of reset, the lit digit is (k / 2^(N-2)) mod 4.
  function automatic int model_digit(input int k, input int n);
    return (k / (1 << (n - 2))) % 4;
  endfunction

  function automatic logic [3:0] model_an(input int d);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << d);
  endfunction

  task automatic check4(input string tag, input int k);
    int d;
    d = model_digit(k, 4);
    chk({tag, "_an"}, an4, model_an(d));
    chk({tag, "_sseg"}, sseg4, a_in[d]);
  endtask

  initial begin
    int k;
    int k2;
    int dwell;
    int edges;
    int first;
    int idx;
    logic valid;

    rst4 = 1'b1; rst2 = 1'b1; rst18 = 1'b1;
    a_in[3] = 8'h80; a_in[2] = 8'h40; a_in[1] = 8'h20; a_in[0] = 8'h10;
    for (int i = 0; i < 4; i++) begin
      b_in[i] = 8'h00;
      c_in[i] = 8'(8'h11 * (i + 1));
    end
    #2;
    rst4 = 1'b0; rst2 = 1'b0; rst18 = 1'b0;
    #1;

    // Reset holds across several edges
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_an", an4, 4'b1110);
      chk("rst_sseg", sseg4, 8'h10);
      chk("rst_q", dut4.q_reg, 0);
    end

    // Scan order over two full refresh periods
    a_in[0] = 8'hF0; a_in[1] = 8'hCC; a_in[2] = 8'hAA; a_in[3] = 8'h81;
    @(negedge clk);
    rst4 = 1'b1;
    k = 0;
    check4("scan", k);
    for (int i = 0; i < 31; i++) begin
      @(posedge clk); #1;
      k++;
      check4("scan", k);
    end

    // Advance to the first cycle of digit 1, then poke inputs live
    for (int i = 0; i < 16 && model_digit(k, 4) != 1; i++) begin
      @(posedge clk); #1;
      k++;
      check4("seek1", k);
    end
    a_in[1] = 8'h3C;
    #1;
    chk("live_sseg", sseg4, 8'h3C);
    chk("live_an", an4, 4'b1101);
    a_in[0] = 8'h55;
    #1;
    chk("live_in0_ignored", sseg4, 8'h3C);

    // Advance to digit 2, then reset between edges
    for (int i = 0; i < 16 && model_digit(k, 4) != 2; i++) begin
      @(posedge clk); #1;
      k++;
      check4("seek2", k);
    end
    chk("pre_async_an", an4, 4'b1011);
    #2;
    rst4 = 1'b0;
    #1;
    chk("async_an", an4, 4'b1110);
    chk("async_sseg", sseg4, a_in[0]);
    chk("async_q", dut4.q_reg, 0);
    @(negedge clk);
    rst4 = 1'b1;
    k = 0;
    dwell = (an4 == 4'b1110) ? 1 : 0;
    check4("post", k);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      k++;
      check4("post", k);
      if (k < 8 && an4 == 4'b1110) dwell++;
    end
    chk("post_dwell", dwell, 4);

    // N=2: digit advances every clock, random patterns
    for (int i = 0; i < 4; i++) b_in[i] = 8'($urandom);
    @(negedge clk);
    rst2 = 1'b1;
    k2 = 0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      k2++;
      valid = 1'b1;
      idx = 0;
      case (an2)
        4'b1110: idx = 0;
        4'b1101: idx = 1;
        4'b1011: idx = 2;
        4'b0111: idx = 3;
        default: valid = 1'b0;
      endcase
      chk("oh_valid", valid, 1);
      chk("oh_sseg_by_an", sseg2, b_in[idx]);
      chk("oh_an_model", an2, model_an(model_digit(k2, 2)));
      for (int j = 0; j < 4; j++) b_in[j] = 8'($urandom);
      #1;
      chk("oh_sseg_live", sseg2, b_in[model_digit(k2, 2)]);
    end

    // Default N=18: first digit change after 2^16 clocks
    @(negedge clk);
    rst18 = 1'b1;
    edges = 0;
    first = -1;
    chk("n18_start_an", an18, 4'b1110);
    while (edges < 70000 && first < 0) begin
      @(posedge clk); #1;
      edges++;
      if (an18 != 4'b1110) first = edges;
    end
    chk("n18_first_change", first, 65536);
    chk("n18_next_an", an18, 4'b1101);
    chk("n18_next_sseg", sseg18, c_in[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
